// File: rtl/serial_tx_arbiter.sv
// Round-robin, message-locked arbiter feeding a depth-1 transmit slot.
// The slot reloads in the same cycle it is dequeued, sustaining one word per cycle.
module serial_tx_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int SW   = 2
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               CLR,
    input  logic [NREQ-1:0]    REQ_VALID,
    input  logic [NREQ-1:0]    REQ_LAST,
    input  logic [NREQ*DW-1:0] REQ_DATA,
    output logic [NREQ-1:0]    REQ_ACK,
    output logic               OUT_EMPTY_N,
    output logic [DW-1:0]      OUT_DATA,
    output logic [SW-1:0]      OUT_SRC,
    output logic               OUT_LAST,
    input  logic               OUT_DEQ,
    output logic               BUSY
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state;
    logic [SW-1:0]   rr_ptr;
    logic [SW-1:0]   owner;
    logic            vld_p0;

    logic            space;
    logic            found;
    logic            accept;
    logic [SW-1:0]   winner;
    logic [SW-1:0]   grant;
    logic [NREQ-1:0] ack;

    // Modulo-NREQ increment so non-power-of-two client counts wrap correctly.
    function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] i);
        if (int'(i) == NREQ - 1)
            return '0;
        else
            return i + 1'b1;
    endfunction

    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ)
                idx = idx - NREQ;
            if (!found && REQ_VALID[idx]) begin
                found  = 1'b1;
                winner = SW'(idx);
            end
        end
    end

    // OUT_DEQ feeds straight through to REQ_ACK so a full slot can be refilled in the dequeue cycle.
    always_comb begin
        space  = !vld_p0 || OUT_DEQ;
        grant  = (state == LOCKED) ? owner : winner;
        accept = 1'b0;
        if (RST_N && !CLR && space) begin
            if (state == LOCKED)
                accept = REQ_VALID[owner];
            else
                accept = found;
        end
        ack = '0;
        if (accept)
            ack[grant] = 1'b1;
    end

    assign REQ_ACK     = ack;
    assign BUSY        = RST_N && (state == LOCKED);
    assign OUT_EMPTY_N = vld_p0;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            vld_p0   <= 1'b0;
            OUT_DATA <= '0;
            OUT_SRC  <= '0;
            OUT_LAST <= 1'b0;
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
        end else if (CLR) begin
            // Slot contents are kept; only the valid flag and arbitration state are dropped.
            vld_p0 <= 1'b0;
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            if (accept) begin
                vld_p0   <= 1'b1;
                OUT_DATA <= REQ_DATA[grant*DW +: DW];
                OUT_SRC  <= grant;
                OUT_LAST <= REQ_LAST[grant];
                if (REQ_LAST[grant]) begin
                    state  <= IDLE;
                    rr_ptr <= wrap_inc(grant);
                end else begin
                    state <= LOCKED;
                    owner <= grant;
                end
            end else if (OUT_DEQ) begin
                vld_p0 <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge CLK) begin
        if (RST_N && !CLR && OUT_DEQ && !vld_p0)
            $warning("dequeue from empty");
    end
`endif

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter: reset, rotation, message lock, backpressure, stall, clear.
module tb_serial_tx_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        CLR;
    logic [3:0]  REQ_VALID;
    logic [3:0]  REQ_LAST;
    logic [31:0] REQ_DATA;
    logic [3:0]  REQ_ACK;
    logic        OUT_EMPTY_N;
    logic [7:0]  OUT_DATA;
    logic [1:0]  OUT_SRC;
    logic        OUT_LAST;
    logic        OUT_DEQ;
    logic        BUSY;

    int total = 0;
    int bad   = 0;

    serial_tx_arbiter #(.NREQ(4), .DW(8), .SW(2)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .CLR         (CLR),
        .REQ_VALID   (REQ_VALID),
        .REQ_LAST    (REQ_LAST),
        .REQ_DATA    (REQ_DATA),
        .REQ_ACK     (REQ_ACK),
        .OUT_EMPTY_N (OUT_EMPTY_N),
        .OUT_DATA    (OUT_DATA),
        .OUT_SRC     (OUT_SRC),
        .OUT_LAST    (OUT_LAST),
        .OUT_DEQ     (OUT_DEQ),
        .BUSY        (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_data(input int i, input logic [7:0] v);
        REQ_DATA[i*8 +: 8] = v;
    endtask

    task automatic do_clr();
        REQ_VALID = 4'b0000;
        CLR       = 1'b1;
        tick();
        CLR       = 1'b0;
    endtask

    initial begin
        RST_N     = 1'b0;
        CLR       = 1'b0;
        OUT_DEQ   = 1'b0;
        REQ_VALID = 4'b1111;
        REQ_LAST  = 4'b1111;
        REQ_DATA  = 32'h13121110;
        tick();

        // reset held with every client requesting
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("rst_ack", REQ_ACK, 4'b0000);
            chk("rst_empty", OUT_EMPTY_N, 1'b0);
            chk("rst_busy", BUSY, 1'b0);
            tick();
        end
        chk("rst_data", OUT_DATA, 8'h00);
        RST_N = 1'b1;
        #1;
        chk("first_ack", REQ_ACK, 4'b0001);

        // single-beat rotation, one word per cycle
        OUT_DEQ = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rot_ack", REQ_ACK, 4'b0001 << (k % 4));
            tick();
            chk("rot_src", OUT_SRC, k % 4);
            chk("rot_data", OUT_DATA, 8'h10 + (k % 4));
            chk("rot_empty", OUT_EMPTY_N, 1'b1);
        end
        do_clr();

        // packet lock: client 0 moves rr_ptr to 1, then client 2 locks
        REQ_VALID = 4'b0001;
        REQ_LAST  = 4'b1111;
        set_data(0, 8'h50);
        #1;
        chk("pl_pre_ack", REQ_ACK, 4'b0001);
        tick();
        REQ_VALID = 4'b0101;
        REQ_LAST  = 4'b1011;
        set_data(2, 8'hA1);
        #1;
        chk("pl_a1_ack", REQ_ACK, 4'b0100);
        tick();
        chk("pl_a1_busy", BUSY, 1'b1);
        chk("pl_a1_data", OUT_DATA, 8'hA1);
        set_data(2, 8'hA2);
        #1;
        chk("pl_a2_ack", REQ_ACK, 4'b0100);
        tick();
        chk("pl_a2_busy", BUSY, 1'b1);
        chk("pl_a2_data", OUT_DATA, 8'hA2);
        set_data(2, 8'hA3);
        REQ_LAST = 4'b1111;
        #1;
        chk("pl_a3_ack", REQ_ACK, 4'b0100);
        tick();
        chk("pl_a3_busy", BUSY, 1'b0);
        chk("pl_a3_data", OUT_DATA, 8'hA3);
        chk("pl_a3_last", OUT_LAST, 1'b1);
        REQ_VALID = 4'b1001;
        #1;
        chk("pl_next3", REQ_ACK, 4'b1000);
        tick();
        #1;
        chk("pl_next0", REQ_ACK, 4'b0001);
        tick();
        do_clr();

        // backpressure on a full slot
        OUT_DEQ   = 1'b0;
        REQ_VALID = 4'b0010;
        set_data(1, 8'h61);
        #1;
        chk("bp_ack0", REQ_ACK, 4'b0010);
        tick();
        set_data(1, 8'h62);
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("bp_hold_ack", REQ_ACK, 4'b0000);
            tick();
            chk("bp_hold_data", OUT_DATA, 8'h61);
        end
        OUT_DEQ = 1'b1;
        #1;
        chk("bp_deq_ack", REQ_ACK, 4'b0010);
        tick();
        chk("bp_new_data", OUT_DATA, 8'h62);
        do_clr();

        // owner stall while another client waits
        REQ_VALID = 4'b0010;
        REQ_LAST  = 4'b1101;
        set_data(1, 8'h71);
        set_data(3, 8'h93);
        #1;
        chk("st_ack", REQ_ACK, 4'b0010);
        tick();
        REQ_VALID = 4'b1000;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("st_wait_ack", REQ_ACK, 4'b0000);
            chk("st_wait_busy", BUSY, 1'b1);
            tick();
        end
        REQ_VALID = 4'b1010;
        REQ_LAST  = 4'b1111;
        set_data(1, 8'h72);
        #1;
        chk("st_resume_ack", REQ_ACK, 4'b0010);
        tick();
        chk("st_resume_data", OUT_DATA, 8'h72);
        chk("st_resume_src", OUT_SRC, 2'd1);
        chk("st_resume_busy", BUSY, 1'b0);
        #1;
        chk("st_then3", REQ_ACK, 4'b1000);
        tick();
        do_clr();

        // clear in the middle of client 0's message with the slot full
        OUT_DEQ   = 1'b1;
        REQ_VALID = 4'b0001;
        REQ_LAST  = 4'b1110;
        set_data(0, 8'h81);
        #1;
        chk("cl_w1_ack", REQ_ACK, 4'b0001);
        tick();
        set_data(0, 8'h82);
        #1;
        chk("cl_w2_ack", REQ_ACK, 4'b0001);
        tick();
        OUT_DEQ   = 1'b0;
        REQ_VALID = 4'b1001;
        #1;
        chk("cl_full_ack", REQ_ACK, 4'b0000);
        chk("cl_full_busy", BUSY, 1'b1);
        CLR = 1'b1;
        #1;
        chk("cl_clr_ack", REQ_ACK, 4'b0000);
        tick();
        CLR = 1'b0;
        chk("cl_empty", OUT_EMPTY_N, 1'b0);
        chk("cl_busy", BUSY, 1'b0);
        chk("cl_data_held", OUT_DATA, 8'h82);
        REQ_VALID = 4'b1000;
        #1;
        chk("cl_grant3", REQ_ACK, 4'b1000);
        tick();
        chk("cl_src3", OUT_SRC, 2'd3);
        chk("cl_data3", OUT_DATA, 8'h93);

        // reset mid-operation zeroes the slot word
        RST_N = 1'b0;
        tick();
        chk("rst2_data", OUT_DATA, 8'h00);
        chk("rst2_src", OUT_SRC, 2'd0);
        chk("rst2_empty", OUT_EMPTY_N, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
